// File: rtl/column_input_ctrl.sv
// Column input controller: debounces left/right/drop buttons, tracks the cursor column and issues validated drop strobes.
// Optional build macro MOVE_AUTOREPEAT_EN enables auto-repeat of held left/right buttons.

module column_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The level only flips after the synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

module column_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_COLS        = 4,
    parameter int WAIT_MAX        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_drop,
    input  logic [15:0] in_gameboard,
    input  logic [1:0]  in_game_status,
    output logic [3:0]  out_column,
    output logic        out_enable,
    output logic [1:0]  cursor,
    output logic        drop_rejected,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_SELECT = 2'd0,
        S_DROP   = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    localparam int          WCW           = $clog2(WAIT_MAX + 1);
    localparam logic [1:0]  LAST_COL      = 2'(NUM_COLS - 1);
    localparam logic [3:0]  TOP_ROW_BASE  = 4'd12;

    state_t         state_q, state_d;
    logic [1:0]     cursor_q, cursor_d;
    logic [15:0]    snap_q, snap_d;
    logic [WCW-1:0] waitCnt_q, waitCnt_d;
    logic           reject_d;
    logic           outEnable_q;
    logic [3:0]     outColumn_q;
    logic           reject_q;
    logic           busy_q;

    logic [2:0]     btnRaw;
    logic [2:0]     levels;
    logic [2:0]     levelPrev_q;
    logic [2:0]     press;
    logic           moveLeft;
    logic           moveRight;
    logic           dropReq;
    logic           gameOver;
    logic           columnFull;
    logic [3:0]     topIdx;

    assign btnRaw = {btn_drop, btn_right, btn_left};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        column_input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clk),
            .rst_ni (reset),
            .btn_i  (btnRaw[i]),
            .level_o(levels[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            levelPrev_q <= '0;
        end else begin
            levelPrev_q <= levels;
        end
    end

    assign press = levels & ~levelPrev_q;

`ifdef MOVE_AUTOREPEAT_EN
    localparam int RCW = $clog2(4 * DEBOUNCE_CYCLES + 1);

    logic [RCW-1:0] repLeft_q, repLeft_d;
    logic [RCW-1:0] repRight_q, repRight_d;
    logic           repLeft;
    logic           repRight;

    assign repLeft  = levels[0] && (repLeft_q == RCW'(4 * DEBOUNCE_CYCLES));
    assign repRight = levels[1] && (repRight_q == RCW'(4 * DEBOUNCE_CYCLES));

    // After the first repeat the counter is rewound so later repeats come every 2*DEBOUNCE_CYCLES
    always_comb begin
        repLeft_d  = '0;
        repRight_d = '0;
        if (levels[0]) begin
            repLeft_d = repLeft ? RCW'(2 * DEBOUNCE_CYCLES + 1) : repLeft_q + 1'b1;
        end
        if (levels[1]) begin
            repRight_d = repRight ? RCW'(2 * DEBOUNCE_CYCLES + 1) : repRight_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            repLeft_q  <= '0;
            repRight_q <= '0;
        end else begin
            repLeft_q  <= repLeft_d;
            repRight_q <= repRight_d;
        end
    end

    assign moveLeft  = press[0] | (repLeft && (state_q != S_WAIT));
    assign moveRight = press[1] | (repRight && (state_q != S_WAIT));
`else
    assign moveLeft  = press[0];
    assign moveRight = press[1];
`endif

    assign dropReq    = press[2];
    assign gameOver   = (in_game_status != 2'b00);
    assign topIdx     = TOP_ROW_BASE + {2'b00, cursor_q};
    assign columnFull = in_gameboard[topIdx];

    // A drop in the same cycle as a move wins and the move is thrown away
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        snap_d    = snap_q;
        waitCnt_d = waitCnt_q;
        reject_d  = 1'b0;
        case (state_q)
            S_SELECT: begin
                if (dropReq) begin
                    if (gameOver || columnFull) begin
                        reject_d = 1'b1;
                    end else begin
                        snap_d  = in_gameboard;
                        state_d = S_DROP;
                    end
                end else if (moveLeft && !moveRight) begin
                    cursor_d = (cursor_q == 2'd0) ? LAST_COL : cursor_q - 1'b1;
                end else if (moveRight && !moveLeft) begin
                    cursor_d = (cursor_q == LAST_COL) ? 2'd0 : cursor_q + 1'b1;
                end
            end
            S_DROP: begin
                waitCnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if ((in_gameboard != snap_q) || (waitCnt_q == WCW'(WAIT_MAX - 1))) begin
                    state_d = S_SELECT;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_SELECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_SELECT;
            cursor_q    <= 2'd0;
            snap_q      <= '0;
            waitCnt_q   <= '0;
            outEnable_q <= 1'b0;
            outColumn_q <= 4'd0;
            reject_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            snap_q      <= snap_d;
            waitCnt_q   <= waitCnt_d;
            outEnable_q <= (state_d == S_DROP);
            outColumn_q <= {2'b00, cursor_d};
            reject_q    <= reject_d;
            busy_q      <= (state_d != S_SELECT);
        end
    end

    assign out_column    = outColumn_q;
    assign out_enable    = outEnable_q;
    assign cursor        = cursor_q;
    assign drop_rejected = reject_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_column_input_ctrl.sv
// Directed testbench for column_input_ctrl with hand-computed expectations (DEBOUNCE_CYCLES=16, WAIT_MAX=8).
// Expectations switch on MOVE_AUTOREPEAT_EN to match the build under test.

module tb_column_input_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_drop = 1'b0;
    logic [15:0] in_gameboard = '0;
    logic [1:0]  in_game_status = 2'b00;
    logic [3:0]  out_column;
    logic        out_enable;
    logic [1:0]  cursor;
    logic        drop_rejected;
    logic        busy;

    int total = 0;
    int bad = 0;

    int enCount, rejCount, moveCount, busyCount;
    int enEdge, rejEdge, moveEdge, moveEdge2;
    logic [3:0] enColumn;
    logic       enBusy;

    column_input_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_drop      (btn_drop),
        .in_gameboard  (in_gameboard),
        .in_game_status(in_game_status),
        .out_column    (out_column),
        .out_enable    (out_enable),
        .cursor        (cursor),
        .drop_rejected (drop_rejected),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBtn(input int which, input logic val);
        case (which)
            1: btn_left = val;
            2: btn_right = val;
            3: btn_drop = val;
            default: ;
        endcase
    endtask

    task automatic doReset();
        reset = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_drop = 1'b0;
        in_gameboard = '0;
        in_game_status = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    // Edge 0 is the first rising edge that samples button A high; all recorded edges use that origin
    task automatic runPress(input int a, input int holdA, input int b, input int startB, input int holdB,
                            input int window, input int boardEdge, input logic [15:0] boardMask);
        logic [1:0] prevCursor;
        enCount = 0; rejCount = 0; moveCount = 0; busyCount = 0;
        enEdge = -1; rejEdge = -1; moveEdge = -1; moveEdge2 = -1;
        enColumn = '0; enBusy = 1'b0;
        prevCursor = cursor;
        setBtn(a, 1'b1);
        if (b != 0 && startB == 0) setBtn(b, 1'b1);
        for (int e = 0; e < window; e++) begin
            @(posedge clk);
            #1;
            if (out_enable) begin
                enCount++;
                if (enEdge < 0) begin
                    enEdge = e;
                    enColumn = out_column;
                    enBusy = busy;
                end
            end
            if (drop_rejected) begin
                rejCount++;
                if (rejEdge < 0) rejEdge = e;
            end
            if (busy) busyCount++;
            if (cursor != prevCursor) begin
                moveCount++;
                if (moveEdge < 0) moveEdge = e;
                else if (moveEdge2 < 0) moveEdge2 = e;
                prevCursor = cursor;
            end
            if (e == holdA - 1) setBtn(a, 1'b0);
            if (b != 0 && e == startB - 1) setBtn(b, 1'b1);
            if (b != 0 && e == startB + holdB - 1) setBtn(b, 1'b0);
            if (e == boardEdge) in_gameboard = in_gameboard | boardMask;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (cursor !== 2'd0) begin bad++; $display("FAIL reset_cursor got=%0d want=0", cursor); end
        total++; if (out_column !== 4'd0) begin bad++; $display("FAIL reset_out_column got=%0d want=0", out_column); end
        total++; if (out_enable !== 1'b0) begin bad++; $display("FAIL reset_out_enable got=%0b want=0", out_enable); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (drop_rejected !== 1'b0) begin bad++; $display("FAIL reset_drop_rejected got=%0b want=0", drop_rejected); end
        btn_right = 1'b1;
        tick();
        reset = 1'b1;
        runPress(2, 20, 0, 0, 0, 60, -1, 16'h0000);
        total++; if (moveEdge != 19) begin bad++; $display("FAIL held_right_latency got=%0d want=19", moveEdge); end
        total++; if (moveCount != 1) begin bad++; $display("FAIL held_right_moves got=%0d want=1", moveCount); end
        total++; if (cursor !== 2'd1) begin bad++; $display("FAIL held_right_cursor got=%0d want=1", cursor); end
        total++; if (out_column !== 4'd1) begin bad++; $display("FAIL held_right_out_column got=%0d want=1", out_column); end
    endtask

    task automatic test_moves();
        int seqRight[5] = '{1, 2, 3, 0, 1};
        int seqLeft[2] = '{0, 3};
        doReset();
        for (int i = 0; i < 5; i++) begin
            runPress(2, 20, 0, 0, 0, 50, -1, 16'h0000);
            total++;
            if (cursor !== 2'(seqRight[i]) || out_column !== 4'(seqRight[i]))
                begin bad++; $display("FAIL right_step%0d got=%0d/%0d want=%0d", i, cursor, out_column, seqRight[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            runPress(1, 20, 0, 0, 0, 50, -1, 16'h0000);
            total++;
            if (cursor !== 2'(seqLeft[i]) || out_column !== 4'(seqLeft[i]))
                begin bad++; $display("FAIL left_step%0d got=%0d/%0d want=%0d", i, cursor, out_column, seqLeft[i]); end
        end
    endtask

    task automatic test_drop();
        doReset();
        runPress(2, 20, 0, 0, 0, 50, -1, 16'h0000);
        runPress(2, 20, 0, 0, 0, 50, -1, 16'h0000);
        total++; if (cursor !== 2'd2) begin bad++; $display("FAIL drop_setup_cursor got=%0d want=2", cursor); end
        runPress(3, 10, 0, 0, 0, 50, -1, 16'h0000);
        total++; if (enCount != 0) begin bad++; $display("FAIL glitch_enable got=%0d want=0", enCount); end
        total++; if (busyCount != 0) begin bad++; $display("FAIL glitch_busy got=%0d want=0", busyCount); end
        runPress(3, 20, 0, 0, 0, 50, 22, 16'h0004);
        total++; if (enEdge != 19) begin bad++; $display("FAIL drop_enable_edge got=%0d want=19", enEdge); end
        total++; if (enCount != 1) begin bad++; $display("FAIL drop_enable_count got=%0d want=1", enCount); end
        total++; if (enColumn !== 4'd2) begin bad++; $display("FAIL drop_out_column got=%0d want=2", enColumn); end
        total++; if (enBusy !== 1'b1) begin bad++; $display("FAIL drop_busy_at_enable got=%0b want=1", enBusy); end
        total++; if (busyCount != 4) begin bad++; $display("FAIL drop_busy_cycles got=%0d want=4", busyCount); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy_end got=%0b want=0", busy); end
    endtask

    task automatic test_reject();
        doReset();
        runPress(2, 20, 0, 0, 0, 50, -1, 16'h0000);
        in_gameboard = 16'h2000;
        runPress(3, 20, 0, 0, 0, 50, -1, 16'h0000);
        total++; if (rejCount != 1) begin bad++; $display("FAIL full_reject_count got=%0d want=1", rejCount); end
        total++; if (rejEdge != 19) begin bad++; $display("FAIL full_reject_edge got=%0d want=19", rejEdge); end
        total++; if (enCount != 0) begin bad++; $display("FAIL full_enable got=%0d want=0", enCount); end
        total++; if (busyCount != 0) begin bad++; $display("FAIL full_busy got=%0d want=0", busyCount); end
        in_gameboard = 16'h0000;
        in_game_status = 2'b01;
        runPress(1, 20, 0, 0, 0, 50, -1, 16'h0000);
        total++; if (cursor !== 2'd0) begin bad++; $display("FAIL gameover_move got=%0d want=0", cursor); end
        runPress(3, 20, 0, 0, 0, 50, -1, 16'h0000);
        total++; if (rejCount != 1) begin bad++; $display("FAIL gameover_reject got=%0d want=1", rejCount); end
        total++; if (enCount != 0) begin bad++; $display("FAIL gameover_enable got=%0d want=0", enCount); end
        in_game_status = 2'b00;
    endtask

    task automatic test_wait_timeout();
        doReset();
        runPress(3, 20, 2, 4, 20, 80, -1, 16'h0000);
        total++; if (enEdge != 19) begin bad++; $display("FAIL wait_enable_edge got=%0d want=19", enEdge); end
        total++; if (busyCount != 9) begin bad++; $display("FAIL wait_busy_cycles got=%0d want=9", busyCount); end
        total++; if (moveCount != 0) begin bad++; $display("FAIL wait_right_ignored got=%0d want=0", moveCount); end
        total++; if (cursor !== 2'd0) begin bad++; $display("FAIL wait_cursor got=%0d want=0", cursor); end
    endtask

    task automatic test_autorepeat();
`ifdef MOVE_AUTOREPEAT_EN
        int wantMoves = 6;
        int wantEdge2 = 83;
        logic [1:0] wantCursor = 2'd2;
`else
        int wantMoves = 1;
        int wantEdge2 = -1;
        logic [1:0] wantCursor = 2'd1;
`endif
        doReset();
        runPress(2, 200, 0, 0, 0, 260, -1, 16'h0000);
        total++; if (moveEdge != 19) begin bad++; $display("FAIL hold_first_move got=%0d want=19", moveEdge); end
        total++; if (moveCount != wantMoves) begin bad++; $display("FAIL hold_move_count got=%0d want=%0d", moveCount, wantMoves); end
        total++; if (moveEdge2 != wantEdge2) begin bad++; $display("FAIL hold_second_move got=%0d want=%0d", moveEdge2, wantEdge2); end
        total++; if (cursor !== wantCursor) begin bad++; $display("FAIL hold_cursor got=%0d want=%0d", cursor, wantCursor); end
    endtask

    task automatic test_reset_abort();
        doReset();
        runPress(2, 20, 0, 0, 0, 50, -1, 16'h0000);
        runPress(3, 20, 0, 0, 0, 21, -1, 16'h0000);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%0b want=1", busy); end
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        total++; if (cursor !== 2'd0 || out_column !== 4'd0) begin bad++; $display("FAIL abort_cursor got=%0d/%0d want=0", cursor, out_column); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_moves();
        test_drop();
        test_reject();
        test_wait_timeout();
        test_autorepeat();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
